phy_mem_ctrl: RTL and testbench



---
 rtl/phy_mem_ctrl_pkg.sv | 23 ++
 rtl/phy_mem_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_phy_mem_ctrl.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/phy_mem_ctrl_pkg.sv
// Shared definitions for the physical SRAM controller: state encoding,
// SRAM geometry and the physical address range check.
package phy_mem_ctrl_pkg;

  localparam int SRAM_ADDR_WIDTH      = 20;
  localparam int SRAM_PHYS_LIMIT_BITS = 22;
  localparam int CNT_W                = 2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD       = 3'd1,
    ST_WR_SETUP = 3'd2,
    ST_WR_PULSE = 3'd3,
    ST_WR_HOLD  = 3'd4,
    ST_DONE1    = 3'd5
  } memctrl_state_e;

  // Any address bit above the SRAM's 4 MiB window makes the access out-of-range.
  function automatic logic is_out_of_range(input logic [31:0] addr);
    return addr[31:SRAM_PHYS_LIMIT_BITS] != '0;
  endfunction

endpackage

// File: rtl/phy_mem_ctrl.sv
// Physical memory controller: turns the CPU's level-held dev_mem request into
// timed asynchronous-SRAM read/write cycles. Completed requests are remembered
// by tag so a request still held after completion is not reissued.
//
// Handshake: the CPU holds addr/is_write/data_out stable while dev_mem_busy is
// high. busy is combinational and rises in the same cycle a new (untagged)
// request appears; the request is complete in the first cycle busy reads low,
// and dev_mem_data_in is valid from that cycle until the next read completes.
module phy_mem_ctrl
  import phy_mem_ctrl_pkg::*;
#(
  parameter int READ_CYCLES  = 2,
  parameter int WRITE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dev_mem_addr,
  input  logic [31:0] dev_mem_data_out,
  input  logic        dev_mem_is_write,
  output logic [31:0] dev_mem_data_in,
  output logic        dev_mem_busy,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
  input  logic [31:0] sram_dq_in,
  output logic [31:0] sram_dq_out,
  output logic        sram_dq_oe,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n
);

  localparam logic [CNT_W-1:0] RD_CNT_INIT = CNT_W'(READ_CYCLES - 1);
  localparam logic [CNT_W-1:0] WR_CNT_INIT = CNT_W'(WRITE_CYCLES - 1);

  memctrl_state_e   state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;

  // Tag of the access in flight and of the last completed access.
  logic [31:0] lat_addr;
  logic [31:0] lat_data;
  logic        lat_is_write;
  logic [31:0] done_addr;
  logic [31:0] done_data;
  logic        done_is_write;
  logic        done_valid;

  logic new_request;
  logic latch_req;
  logic complete;
  logic capture_rd;
  logic zero_rd;

  // A request is new unless it matches the last completed tag exactly;
  // write data only takes part in the tag for writes.
  always_comb begin
    new_request = !done_valid
               || (dev_mem_addr != done_addr)
               || (dev_mem_is_write != done_is_write)
               || (dev_mem_is_write && (dev_mem_data_out != done_data));
  end

  assign dev_mem_busy = new_request || (state != ST_IDLE);

  // Next-state and per-cycle control decode.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    latch_req  = 1'b0;
    complete   = 1'b0;
    capture_rd = 1'b0;
    zero_rd    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (new_request) begin
          latch_req = 1'b1;
          if (is_out_of_range(dev_mem_addr)) begin
            state_next = ST_DONE1;
          end else if (dev_mem_is_write) begin
            state_next = ST_WR_SETUP;
          end else begin
            state_next = ST_RD;
            cnt_next   = RD_CNT_INIT;
          end
        end
      end
      ST_RD: begin
        if (cnt == '0) begin
          capture_rd = 1'b1;
          complete   = 1'b1;
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      ST_WR_SETUP: begin
        state_next = ST_WR_PULSE;
        cnt_next   = WR_CNT_INIT;
      end
      ST_WR_PULSE: begin
        if (cnt == '0) begin
          state_next = ST_WR_HOLD;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      ST_WR_HOLD: begin
        complete   = 1'b1;
        state_next = ST_IDLE;
      end
      ST_DONE1: begin
        complete   = 1'b1;
        zero_rd    = !lat_is_write;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State register and cycle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Latch the accepted request tag and record it as done on completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_addr      <= '0;
      lat_data      <= '0;
      lat_is_write  <= 1'b0;
      done_addr     <= '0;
      done_data     <= '0;
      done_is_write <= 1'b0;
      done_valid    <= 1'b0;
    end else begin
      if (latch_req) begin
        lat_addr     <= dev_mem_addr;
        lat_data     <= dev_mem_data_out;
        lat_is_write <= dev_mem_is_write;
      end
      if (complete) begin
        done_addr     <= lat_addr;
        done_data     <= lat_data;
        done_is_write <= lat_is_write;
        done_valid    <= 1'b1;
      end
    end
  end

  // Read data register: SRAM data on a real read, zero on an out-of-range read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dev_mem_data_in <= '0;
    end else if (capture_rd) begin
      dev_mem_data_in <= sram_dq_in;
    end else if (zero_rd) begin
      dev_mem_data_in <= '0;
    end
  end

  // SRAM pins registered from the next state so strobes are glitch-free and
  // address/data only move when leaving IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_ce_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      sram_we_n   <= 1'b1;
    end else begin
      if (latch_req) begin
        sram_addr <= dev_mem_addr[SRAM_PHYS_LIMIT_BITS-1:2];
        if (dev_mem_is_write) begin
          sram_dq_out <= dev_mem_data_out;
        end
      end
      sram_ce_n  <= !(state_next inside {ST_RD, ST_WR_SETUP, ST_WR_PULSE, ST_WR_HOLD});
      sram_oe_n  <= !(state_next == ST_RD);
      sram_we_n  <= !(state_next == ST_WR_PULSE);
      sram_dq_oe <= state_next inside {ST_WR_SETUP, ST_WR_PULSE, ST_WR_HOLD};
    end
  end

endmodule

// File: tb/tb_phy_mem_ctrl.sv
// Bench for phy_mem_ctrl: default-parameter instance against an SRAM model
// driven from a vector table, plus a READ_CYCLES=4 / WRITE_CYCLES=1 instance.
module tb_phy_mem_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT 1 (defaults) ----------------
  logic [31:0] addr, wdata, rdata;
  logic        is_write, busy;
  logic [19:0] sram_addr;
  logic [31:0] dq_in, dq_out;
  logic        dq_oe, ce_n, oe_n, we_n;

  phy_mem_ctrl dut (
    .clk(clk), .rst(rst),
    .dev_mem_addr(addr), .dev_mem_data_out(wdata), .dev_mem_is_write(is_write),
    .dev_mem_data_in(rdata), .dev_mem_busy(busy),
    .sram_addr(sram_addr), .sram_dq_in(dq_in), .sram_dq_out(dq_out),
    .sram_dq_oe(dq_oe), .sram_ce_n(ce_n), .sram_oe_n(oe_n), .sram_we_n(we_n)
  );

  // ---------------- DUT 2 (READ_CYCLES=4, WRITE_CYCLES=1) ----------------
  logic [31:0] addr2, wdata2, rdata2;
  logic        is_write2, busy2;
  logic [19:0] sram_addr2;
  logic [31:0] dq_in2, dq_out2;
  logic        dq_oe2, ce_n2, oe_n2, we_n2;

  phy_mem_ctrl #(.READ_CYCLES(4), .WRITE_CYCLES(1)) dut2 (
    .clk(clk), .rst(rst),
    .dev_mem_addr(addr2), .dev_mem_data_out(wdata2), .dev_mem_is_write(is_write2),
    .dev_mem_data_in(rdata2), .dev_mem_busy(busy2),
    .sram_addr(sram_addr2), .sram_dq_in(dq_in2), .sram_dq_out(dq_out2),
    .sram_dq_oe(dq_oe2), .sram_ce_n(ce_n2), .sram_oe_n(oe_n2), .sram_we_n(we_n2)
  );

  // Second instance sees a fixed address-derived pattern.
  assign dq_in2 = (!ce_n2 && !oe_n2) ? {12'hA5A, sram_addr2} : 32'h0;

  // ---------------- SRAM model for DUT 1 ----------------
  logic [31:0] mem [logic [19:0]];

  always @(ce_n or oe_n or sram_addr) begin
    if (!ce_n && !oe_n)
      dq_in = mem.exists(sram_addr) ? mem[sram_addr] : 32'h0;
    else
      dq_in = 32'hBAD0BAD0;
  end

  // Asynchronous SRAM latches write data on the rising edge of we_n.
  always @(posedge we_n) begin
    if (!rst && !ce_n && dq_oe) mem[sram_addr] = dq_out;
  end

  // ---------------- scoreboard / counters ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [39:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- strobe monitor ----------------
  int          oe_cnt = 0, we_cnt = 0, we2_cnt = 0;
  logic [19:0] we_addr = '0;
  logic [31:0] we_data = '0;
  logic        prev_we_n = 1'b1, prev_dq_oe = 1'b0;
  logic        shape_en = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (!oe_n) oe_cnt++;
      if (!we_n2) we2_cnt++;
      if (!we_n) begin
        we_cnt++;
        we_addr = sram_addr;
        we_data = dq_out;
      end
      if (shape_en && prev_we_n && !we_n) check("wr_setup_drive", {63'd0, prev_dq_oe}, 64'd1);
      if (shape_en && !prev_we_n && we_n) check("wr_hold_drive", {62'd0, dq_oe, ce_n}, 64'd2);
    end
    prev_we_n  = we_n;
    prev_dq_oe = dq_oe;
  end

  // ---------------- driver tasks ----------------
  // Counts cycles from the current one (cycle 0) until busy samples low.
  task automatic wait_idle(output int lat, output bit ok);
    lat = 0;
    ok  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
      @(posedge clk);
      lat++;
    end
  endtask

  task automatic run_access(input string name, input logic [31:0] a, input logic wr,
                            input logic [31:0] d, input logic [31:0] exp_rd, input int exp_lat);
    int lat;
    bit ok;
    logic [39:0] e;
    exp_q.push_back({exp_lat[7:0], exp_rd});
    @(posedge clk);
    #1;
    addr = a; is_write = wr; wdata = d;
    oe_cnt = 0; we_cnt = 0;
    wait_idle(lat, ok);
    e = exp_q.pop_front();
    check({name, "_timeout"}, {63'd0, ok}, 64'd1);
    check({name, "_lat"}, 64'(lat), 64'(e[39:32]));
    check({name, "_data"}, {32'd0, rdata}, {32'd0, e[31:0]});
  endtask

  task automatic run_access2(input string name, input logic [31:0] a, input logic wr,
                             input logic [31:0] d, input logic [31:0] exp_rd, input int exp_lat);
    int lat;
    bit ok;
    logic [39:0] e;
    exp_q.push_back({exp_lat[7:0], exp_rd});
    @(posedge clk);
    #1;
    addr2 = a; is_write2 = wr; wdata2 = d;
    we2_cnt = 0;
    lat = 0;
    ok  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy2) begin ok = 1'b1; break; end
      @(posedge clk);
      lat++;
    end
    e = exp_q.pop_front();
    check({name, "_timeout"}, {63'd0, ok}, 64'd1);
    check({name, "_lat"}, 64'(lat), 64'(e[39:32]));
    check({name, "_data"}, {32'd0, rdata2}, {32'd0, e[31:0]});
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
    int          oe;
    int          we;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int lat;
    bit ok;
    logic [31:0] rnd;

    vecs[0]  = '{"rd_40",       32'h0000_0040, 1'b0, 32'h0,         32'hDEADBEEF, 3, 2, 0};
    vecs[1]  = '{"wr_top",      32'h003F_FFFC, 1'b1, 32'h1234_5678, 32'hDEADBEEF, 5, 0, 2};
    vecs[2]  = '{"rd_top",      32'h003F_FFFC, 1'b0, 32'h0,         32'h1234_5678, 3, 2, 0};
    vecs[3]  = '{"rd_top_rep",  32'h003F_FFFC, 1'b0, 32'h0,         32'h1234_5678, 0, 0, 0};
    vecs[4]  = '{"rd_oor",      32'h0040_0000, 1'b0, 32'h0,         32'h0,         2, 0, 0};
    vecs[5]  = '{"wr_oor",      32'h8000_0000, 1'b1, 32'h1111_1111, 32'h0,         2, 0, 0};
    vecs[6]  = '{"rd_w0",       32'h0000_0003, 1'b0, 32'h0,         32'h0BAD_F00D, 3, 2, 0};
    vecs[7]  = '{"wr_a55",      32'h0000_0100, 1'b1, 32'h0000_0055, 32'h0BAD_F00D, 5, 0, 2};
    vecs[8]  = '{"rd_a",        32'h0000_0100, 1'b0, 32'h0,         32'h0000_0055, 3, 2, 0};
    vecs[9]  = '{"rd_a_rep",    32'h0000_0100, 1'b0, 32'h0,         32'h0000_0055, 0, 0, 0};
    vecs[10] = '{"wr_a55_new",  32'h0000_0100, 1'b1, 32'h0000_0055, 32'h0000_0055, 5, 0, 2};
    vecs[11] = '{"wr_a55_rep",  32'h0000_0100, 1'b1, 32'h0000_0055, 32'h0000_0055, 0, 0, 0};
    vecs[12] = '{"wr_aAA",      32'h0000_0100, 1'b1, 32'h0000_00AA, 32'h0000_0055, 5, 0, 2};
    vecs[13] = '{"rd_a_alias",  32'h0000_0102, 1'b0, 32'h0,         32'h0000_00AA, 3, 2, 0};

    mem[20'h00010] = 32'hDEADBEEF;
    mem[20'h00000] = 32'h0BAD_F00D;
    addr = '0; wdata = '0; is_write = 1'b0;
    addr2 = '0; wdata2 = '0; is_write2 = 1'b0;

    // Reset state.
    #12;
    check("rst_data_in", {32'd0, rdata}, 64'd0);
    check("rst_sram_addr", {44'd0, sram_addr}, 64'd0);
    check("rst_dq_out", {32'd0, dq_out}, 64'd0);
    check("rst_ctrl", {60'd0, dq_oe, ce_n, oe_n, we_n}, 64'h7);
    check("rst_busy", {63'd0, busy}, 64'd1);

    // Leaving reset with a read of word 0 held: served from IDLE.
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_idle(lat, ok);
    check("post_rst_ok", {63'd0, ok}, 64'd1);
    check("post_rst_lat", 64'(lat), 64'd3);
    check("post_rst_data", {32'd0, rdata}, 64'h0BAD_F00D);

    // Table-driven accesses.
    shape_en = 1'b1;
    for (int i = 0; i < 14; i++) begin
      run_access(vecs[i].name, vecs[i].addr, vecs[i].wr, vecs[i].wdata, vecs[i].rdata, vecs[i].lat);
      check({vecs[i].name, "_oe_cycles"}, 64'(oe_cnt), 64'(vecs[i].oe));
      check({vecs[i].name, "_we_cycles"}, 64'(we_cnt), 64'(vecs[i].we));
      if (vecs[i].we != 0) begin
        check({vecs[i].name, "_we_addr"}, {44'd0, we_addr}, {44'd0, vecs[i].addr[21:2]});
        check({vecs[i].name, "_we_data"}, {32'd0, we_data}, {32'd0, vecs[i].wdata});
      end
    end
    check("model_top", {32'd0, mem[20'hFFFFF]}, 64'h1234_5678);
    check("model_w0_kept", {32'd0, mem[20'h00000]}, 64'h0BAD_F00D);
    shape_en = 1'b0;

    // Reset in the middle of the write pulse.
    rnd = $urandom_range(32'h7FFF_FFFF, 1);
    @(posedge clk);
    #1;
    addr = 32'h0000_0200; is_write = 1'b1; wdata = rnd;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!we_n) begin ok = 1'b1; break; end
    end
    check("rst_mid_reach_pulse", {63'd0, ok}, 64'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_ctrl", {60'd0, dq_oe, ce_n, oe_n, we_n}, 64'h7);
    check("rst_mid_busy", {63'd0, busy}, 64'd1);
    check("rst_mid_no_write", {63'd0, mem.exists(20'h00080)}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    we_cnt = 0;
    wait_idle(lat, ok);
    check("rst_mid_reserve_ok", {63'd0, ok}, 64'd1);
    check("rst_mid_reserve_lat", 64'(lat), 64'd5);
    check("rst_mid_we_cycles", 64'(we_cnt), 64'd2);
    check("rst_mid_model", {32'd0, mem[20'h00080]}, {32'd0, rnd});

    // Parameter variant: READ_CYCLES=4, WRITE_CYCLES=1.
    run_access2("p_rd", 32'h0000_0020, 1'b0, 32'h0, 32'hA5A0_0008, 5);
    run_access2("p_wr", 32'h0000_0024, 1'b1, 32'h0000_0001, 32'hA5A0_0008, 4);
    check("p_wr_we_cycles", 64'(we2_cnt), 64'd1);
    run_access2("p_wr_rep", 32'h0000_0024, 1'b1, 32'h0000_0001, 32'hA5A0_0008, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard stop if something hangs beyond all bounded waits.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
